mem_port_arbiter: RTL

//  Shares the single memory port between instruction fetch (IFU) and load/store (MEM stage).

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between instruction fetch and
//                load/store. LSU has fixed priority, bounded by an
//                anti-starvation counter. One transaction is outstanding at a
//                time, and a timeout forces an error completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic        ifu_rsp_err,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [3:0]  lsu_wmask,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_rsp_valid,
    output logic        lsu_rsp_err,
    output logic [31:0] lsu_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam int               c_sw         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_sw-1:0]  c_starve_max = c_sw'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_tmo_last   = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic             c_tmo_en     = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t            state_q,         state_d;
    logic              owner_lsu_q,     owner_lsu_d;
    logic [c_sw-1:0]   starve_cnt_q,    starve_cnt_d;
    logic [CNT_W-1:0]  tmo_cnt_q,       tmo_cnt_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [31:0]       mem_addr_q,      mem_addr_d;
    logic              mem_wen_q,       mem_wen_d;
    logic [3:0]        mem_wmask_q,     mem_wmask_d;
    logic [31:0]       mem_wdata_q,     mem_wdata_d;
    logic              busy_q,          busy_d;

    logic w_lsu_win;
    logic w_ifu_win;
    logic w_idle;
    logic w_in_flight;
    logic w_complete;
    logic w_timeout;
    logic w_rsp;

    // Arbitration: LSU first, except when the fetch side has been passed over too often.
    always_comb begin
        w_lsu_win     = lsu_req_valid && !((starve_cnt_q == c_starve_max) && ifu_req_valid);
        w_ifu_win     = ifu_req_valid && !w_lsu_win;
        w_idle        = (state_q == IDLE) && rst_n;
        ifu_req_ready = w_idle && w_ifu_win;
        lsu_req_ready = w_idle && w_lsu_win;
    end

    always_comb begin
        w_in_flight = (state_q == REQ) || (state_q == RSP);
        w_complete  = (state_q == RSP) && mem_rsp_valid;
        // A real completion always beats an expiring timeout in the same cycle.
        w_timeout   = c_tmo_en && w_in_flight && (tmo_cnt_q == c_tmo_last) && !w_complete;
        w_rsp       = w_complete || w_timeout;
    end

    always_comb begin
        ifu_rsp_valid = w_rsp && !owner_lsu_q;
        ifu_rsp_err   = w_timeout && !owner_lsu_q;
        ifu_rdata     = (w_complete && !owner_lsu_q) ? mem_rdata : 32'h0;
        lsu_rsp_valid = w_rsp && owner_lsu_q;
        lsu_rsp_err   = w_timeout && owner_lsu_q;
        lsu_rdata     = (w_complete && owner_lsu_q) ? mem_rdata : 32'h0;
    end

    always_comb begin
        state_d      = state_q;
        owner_lsu_d  = owner_lsu_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (w_lsu_win || w_ifu_win) begin
                    state_d     = REQ;
                    owner_lsu_d = w_lsu_win;
                    tmo_cnt_d   = '0;
                    if (w_lsu_win) begin
                        mem_addr_d  = lsu_addr;
                        mem_wen_d   = lsu_wen;
                        mem_wmask_d = lsu_wmask;
                        mem_wdata_d = lsu_wdata;
                    end else begin
                        mem_addr_d  = ifu_addr;
                        mem_wen_d   = 1'b0;
                        mem_wmask_d = 4'h0;
                        mem_wdata_d = 32'h0;
                    end
                    if (w_lsu_win && ifu_req_valid) begin
                        if (starve_cnt_q != c_starve_max) begin
                            starve_cnt_d = starve_cnt_q + c_sw'(1);
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end
            REQ: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (w_timeout) begin
                    state_d = IDLE;
                end else if (mem_req_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (w_rsp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_valid_d = (state_d == REQ);
        busy_d          = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            owner_lsu_q     <= 1'b0;
            starve_cnt_q    <= '0;
            tmo_cnt_q       <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wen_q       <= 1'b0;
            mem_wmask_q     <= 4'h0;
            mem_wdata_q     <= 32'h0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_lsu_q     <= owner_lsu_d;
            starve_cnt_q    <= starve_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wmask_q     <= mem_wmask_d;
            mem_wdata_q     <= mem_wdata_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wmask     = mem_wmask_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire
